// File: rtl/inst_fetch_queue_if.sv
// Fetch-to-decoder bundle: fetch push slots, decoder dequeue count and the two oldest entries.
interface inst_fetch_queue_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          in_valid_A;
    logic          in_valid_B;
    logic [31:0]   in_instA;
    logic [31:0]   in_instB;
    logic [31:0]   in_pcA;
    logic [31:0]   in_pcB;
    logic          in_ready;
    logic [1:0]    deq_count;
    logic [31:0]   instA;
    logic [31:0]   instB;
    logic [31:0]   pcA;
    logic [31:0]   pcB;
    logic          valid_A;
    logic          valid_B;
    logic [CW-1:0] count;
    logic          overflow_err;

    modport master (
        output flush, in_valid_A, in_valid_B, in_instA, in_instB, in_pcA, in_pcB, deq_count,
        input  in_ready, instA, instB, pcA, pcB, valid_A, valid_B, count, overflow_err
    );

    modport slave (
        input  flush, in_valid_A, in_valid_B, in_instA, in_instB, in_pcA, in_pcB, deq_count,
        output in_ready, instA, instB, pcA, pcB, valid_A, valid_B, count, overflow_err
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// 2-in/2-out instruction queue; push visible 1 cycle later (same cycle on empty with IFQ_BYPASS_EN).
// in_ready needs 2 free entries; a push without it is dropped and latches overflow_err.
module inst_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst_n,
    inst_fetch_queue_if.slave  ifq
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]   inst_mem [DEPTH];
    logic [31:0]   pc_mem   [DEPTH];

    logic [AW-1:0] head_q, head_d, tail_q, tail_d, head1, tail1;
    logic [CW-1:0] count_q, count_d, avail;
    logic          ovf_q, ovf_d;
    logic          in_ready, push_ok, bypass;
    logic [1:0]    push_n, push_eff, deq_n, pop_n;
    logic [31:0]   raw_instA, raw_instB, raw_pcA, raw_pcB;
    logic          vld_a, vld_b;

    always_comb begin
        in_ready = (count_q <= CW'(DEPTH - 2));
        push_n   = !ifq.in_valid_A ? 2'd0 : (ifq.in_valid_B ? 2'd2 : 2'd1);
        push_ok  = in_ready && !ifq.flush;
        push_eff = push_ok ? push_n : 2'd0;
        deq_n    = (ifq.deq_count == 2'd3) ? 2'd2 : ifq.deq_count;
`ifdef IFQ_BYPASS_EN
        // On an empty queue the incoming pair is already visible, so it can be consumed.
        bypass   = (count_q == '0) && !ifq.flush;
        avail    = bypass ? CW'(push_eff) : count_q;
`else
        bypass   = 1'b0;
        avail    = count_q;
`endif
        pop_n    = (CW'(deq_n) > avail) ? avail[1:0] : deq_n;
        head1    = head_q + AW'(1);
        tail1    = tail_q + AW'(1);

        head_d   = head_q + AW'(pop_n);
        tail_d   = tail_q + AW'(push_eff);
        count_d  = count_q + CW'(push_eff) - CW'(pop_n);
        ovf_d    = ovf_q | (ifq.in_valid_A && !in_ready);
        if (ifq.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage is not reset; entries are only ever read behind a valid count.
    always_ff @(posedge clk) begin
        if (rst_n && push_eff != 2'd0) begin
            inst_mem[tail_q] <= ifq.in_instA;
            pc_mem[tail_q]   <= ifq.in_pcA;
        end
        if (rst_n && push_eff == 2'd2) begin
            inst_mem[tail1] <= ifq.in_instB;
            pc_mem[tail1]   <= ifq.in_pcB;
        end
    end

    always_comb begin
        if (bypass) begin
            vld_a     = ifq.in_valid_A;
            vld_b     = ifq.in_valid_A && ifq.in_valid_B;
            raw_instA = ifq.in_instA;
            raw_instB = ifq.in_instB;
            raw_pcA   = ifq.in_pcA;
            raw_pcB   = ifq.in_pcB;
        end else begin
            vld_a     = (count_q >= CW'(1));
            vld_b     = (count_q >= CW'(2));
            raw_instA = inst_mem[head_q];
            raw_instB = inst_mem[head1];
            raw_pcA   = pc_mem[head_q];
            raw_pcB   = pc_mem[head1];
        end
    end

    assign ifq.valid_A      = vld_a;
    assign ifq.valid_B      = vld_b;
    assign ifq.instA        = vld_a ? raw_instA : NOP_INST;
    assign ifq.instB        = vld_b ? raw_instB : NOP_INST;
    assign ifq.pcA          = vld_a ? raw_pcA : 32'h0;
    assign ifq.pcB          = vld_b ? raw_pcB : 32'h0;
    assign ifq.in_ready     = in_ready;
    assign ifq.count        = count_q;
    assign ifq.overflow_err = ovf_q;
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with DEPTH=8; expectations follow IFQ_BYPASS_EN when defined.
module tb_inst_fetch_queue;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    inst_fetch_queue_if #(.DEPTH(8)) ifq ();

    inst_fetch_queue #(.DEPTH(8), .NOP_INST(NOP)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ifq   (ifq.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        ifq.flush      = 1'b0;
        ifq.in_valid_A = 1'b0;
        ifq.in_valid_B = 1'b0;
        ifq.deq_count  = 2'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic drive(input logic va, input logic vb, input logic [31:0] pa, input logic [31:0] ia,
                         input logic [31:0] pb, input logic [31:0] ib, input logic [1:0] deq);
        ifq.in_valid_A = va;
        ifq.in_valid_B = vb;
        ifq.in_pcA     = pa;
        ifq.in_instA   = ia;
        ifq.in_pcB     = pb;
        ifq.in_instB   = ib;
        ifq.deq_count  = deq;
    endtask

    function automatic logic [31:0] iw(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    initial begin
        idle();
        ifq.in_instA = '0; ifq.in_instB = '0; ifq.in_pcA = '0; ifq.in_pcB = '0;
        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", ifq.in_ready, 1);
        chk("rst_valid_A", ifq.valid_A, 0);
        chk("rst_valid_B", ifq.valid_B, 0);
        chk("rst_instA", ifq.instA, NOP);
        chk("rst_instB", ifq.instB, NOP);
        chk("rst_pcA", ifq.pcA, 0);
        chk("rst_pcB", ifq.pcB, 0);
        chk("rst_count", ifq.count, 0);
        chk("rst_ovf", ifq.overflow_err, 0);
        rst_n = 1'b1;

        // first pair
        drive(1, 1, 32'h0, 32'h00500093, 32'h4, 32'h00a00113, 2'd0);
        tick();
        chk("p1_count", ifq.count, 2);
        chk("p1_valid_A", ifq.valid_A, 1);
        chk("p1_valid_B", ifq.valid_B, 1);
        chk("p1_instA", ifq.instA, 32'h00500093);
        chk("p1_instB", ifq.instB, 32'h00a00113);
        chk("p1_pcB", ifq.pcB, 32'h4);

        // fill to 6, then push+pop at DEPTH-2
        drive(1, 1, 32'h8, iw(8), 32'hC, iw(12), 2'd0);
        tick();
        drive(1, 1, 32'h10, iw(16), 32'h14, iw(20), 2'd0);
        tick();
        chk("c6_count", ifq.count, 6);
        chk("c6_in_ready", ifq.in_ready, 1);
        drive(1, 1, 32'h18, iw(24), 32'h1C, iw(28), 2'd2);
        tick();
        chk("c6pp_count", ifq.count, 6);
        chk("c6pp_pcA", ifq.pcA, 32'h8);
        drive(1, 1, 32'h20, iw(32), 32'h24, iw(36), 2'd0);
        tick();
        chk("full_count", ifq.count, 8);
        chk("full_in_ready", ifq.in_ready, 0);
        chk("full_ovf_pre", ifq.overflow_err, 0);

        // overflow attempt
        drive(1, 1, 32'h99, iw(32'h99), 32'h9D, iw(32'h9D), 2'd0);
        tick();
        chk("ovf_set", ifq.overflow_err, 1);
        chk("ovf_count", ifq.count, 8);
        chk("ovf_pcA", ifq.pcA, 32'h8);

        drive(0, 0, 0, 0, 0, 0, 2'd1);
        tick();
        chk("c7_count", ifq.count, 7);
        chk("c7_in_ready", ifq.in_ready, 0);
        chk("c7_pcA", ifq.pcA, 32'hC);
        chk("c7_pcB", ifq.pcB, 32'h10);

        drive(0, 0, 0, 0, 0, 0, 2'd2);
        tick();
        chk("d2_count", ifq.count, 5);
        chk("d2_pcA", ifq.pcA, 32'h14);
        drive(0, 0, 0, 0, 0, 0, 2'd3);
        tick();
        chk("d3_count", ifq.count, 3);
        chk("d3_pcA", ifq.pcA, 32'h1C);
        chk("d3_instA", ifq.instA, iw(28));
        drive(0, 0, 0, 0, 0, 0, 2'd1);
        tick();
        chk("w0_count", ifq.count, 2);
        chk("w0_pcA", ifq.pcA, 32'h20);
        chk("w0_pcB", ifq.pcB, 32'h24);

        // steady 2-in/2-out across the wrap boundary
        for (int k = 1; k <= 10; k++) begin
            logic [31:0] np;
            np = 32'h20 + 32'(8 * k);
            drive(1, 1, np, iw(np), np + 32'h4, iw(np + 32'h4), 2'd2);
            tick();
            chk("wrap_count", ifq.count, 2);
            chk("wrap_pcA", ifq.pcA, np);
            chk("wrap_pcB", ifq.pcB, np + 32'h4);
            chk("wrap_instA", ifq.instA, iw(np));
        end

        // over-dequeue from count=1
        drive(0, 0, 0, 0, 0, 0, 2'd1);
        tick();
        chk("c1_count", ifq.count, 1);
        chk("c1_pcA", ifq.pcA, 32'h74);
        chk("c1_valid_B", ifq.valid_B, 0);
        drive(0, 0, 0, 0, 0, 0, 2'd2);
        tick();
        chk("od_count", ifq.count, 0);
        chk("od_valid_A", ifq.valid_A, 0);
        chk("od_instA", ifq.instA, NOP);
        chk("od_pcA", ifq.pcA, 0);

        // flush beats push and pop
        drive(1, 1, 32'hC8, iw(200), 32'hCC, iw(204), 2'd0);
        tick();
        drive(1, 1, 32'hD0, iw(208), 32'hD4, iw(212), 2'd0);
        tick();
        drive(1, 0, 32'hD8, iw(216), 32'h0, 32'h0, 2'd0);
        tick();
        chk("fl_pre_count", ifq.count, 5);
        drive(1, 1, 32'hE0, iw(224), 32'hE4, iw(228), 2'd2);
        ifq.flush = 1'b1;
        tick();
        chk("fl_count", ifq.count, 0);
        chk("fl_valid_A", ifq.valid_A, 0);
        chk("fl_in_ready", ifq.in_ready, 1);
        chk("fl_ovf_kept", ifq.overflow_err, 1);

        // reset mid-operation
        drive(1, 1, 32'h100, iw(256), 32'h104, iw(260), 2'd0);
        tick();
        chk("mr_pre_count", ifq.count, 2);
        drive(1, 1, 32'h108, iw(264), 32'h10C, iw(268), 2'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mr_count", ifq.count, 0);
        chk("mr_ovf", ifq.overflow_err, 0);
        chk("mr_valid_A", ifq.valid_A, 0);

        // empty queue, push two, consume one in the same cycle
        drive(1, 1, 32'h200, 32'h11111111, 32'h204, 32'h22222222, 2'd1);
        #1;
`ifdef IFQ_BYPASS_EN
        chk("byp_instA", ifq.instA, 32'h11111111);
        chk("byp_instB", ifq.instB, 32'h22222222);
        chk("byp_valid_B", ifq.valid_B, 1);
        tick();
        chk("byp_next_instA", ifq.instA, 32'h22222222);
        chk("byp_next_pcA", ifq.pcA, 32'h204);
        chk("byp_next_count", ifq.count, 1);
`else
        chk("nb_instA", ifq.instA, NOP);
        chk("nb_valid_A", ifq.valid_A, 0);
        chk("nb_valid_B", ifq.valid_B, 0);
        tick();
        chk("nb_next_instA", ifq.instA, 32'h11111111);
        chk("nb_next_pcB", ifq.pcB, 32'h204);
        chk("nb_next_count", ifq.count, 2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/inst_fetch_queue.md
# inst_fetch_queue

Dual-entry-per-cycle instruction queue between fetch and the dual-issue decoder. It accepts up to two instruction/PC pairs per cycle from fetch and presents the two oldest to the decoder's instA/pcA and instB/pcB inputs. The decoder/dispatch side retires 0, 1 or 2 entries per cycle. The queue is discarded on a front-end redirect (jump, branch, fence, ecall or ebreak flush).

## Interface
Parameters:
- DEPTH, 8, number of entries; must be a power of two and at least 4
- NOP_INST, 32'h00000013, instruction presented on an invalid output slot (addi x0,x0,0)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  reset; synchronous, active-low
- flush  in  1  discard all entries and any push in the same cycle
- in_valid_A  in  1  fetch slot A carries an instruction
- in_valid_B  in  1  fetch slot B carries an instruction; ignored unless in_valid_A
- in_instA, in_instB  in  32 each  fetched instructions; A is older
- in_pcA, in_pcB  in  32 each  PCs of the fetched instructions
- in_ready  out  1  at least 2 free entries this cycle
- deq_count  in  2  entries consumed this cycle (0, 1 or 2); value 3 is treated as 2
- instA, instB  out  32 each  oldest and second-oldest instructions, to the decoder
- pcA, pcB  out  32 each  PCs of instA and instB
- valid_A, valid_B  out  1 each  instA/instB hold a real entry
- count  out  $clog2(DEPTH)+1  current occupancy
- overflow_err  out  1  sticky: a push was attempted while in_ready=0

## Operation
- Storage is DEPTH entries of {pc, inst}. head and tail pointers are $clog2(DEPTH) bits wide and wrap modulo DEPTH. Occupancy is held in the separate count register.
- Push count: push_n = 0 if !in_valid_A; 1 if in_valid_A && !in_valid_B; 2 if both.
  - A is written to tail and B to tail+1, wrapping.
  - tail advances by push_n.
- Push is accepted only when in_ready=1 and flush=0.
  - in_valid_A=1 with in_ready=0 drops the push, sets overflow_err, and leaves the queue unchanged.
- Pop count: pop_n = min(deq_count clamped to 2, count). Over-dequeue is clamped and is not an error. head advances by pop_n.
- count_next = count + push_n - pop_n. Simultaneous push and pop in the same cycle is legal, including when count=DEPTH-2.
- in_ready = (DEPTH - count >= 2). It depends only on the registered count, not on deq_count or the in_* inputs.
- Output slots:
  - valid_A = (count >= 1); valid_B = (count >= 2).
  - instA/pcA come from entry[head]; instB/pcB come from entry[head+1].
  - Any invalid slot drives inst = NOP_INST and pc = 32'h0.
- Flush sets head=tail=count=0 and drops that cycle's push and pop. overflow_err is not cleared.
- Reset: head=tail=count=0, overflow_err=0. Storage contents are not reset.

## Timing
- Reset values: in_ready=1, valid_A=valid_B=0, instA=instB=NOP_INST, pcA=pcB=0, count=0, overflow_err=0.
- Outputs are combinational from registered state: head, count and storage.
- Push-to-output latency is 1 cycle; an entry pushed at edge N is visible on instA/instB after edge N.
- Dequeue takes effect at the edge: the decoder samples instA/instB during the cycle, drives deq_count, and the next entries appear after the edge.
- Flush has priority over push, pop and bypass. Reset has priority over flush.
- Reset asserted mid-operation empties the queue at the next edge, whatever the in-flight pushes are.

## Configuration
- IFQ_BYPASS_EN defined: when count=0 and flush=0, the in_* slots drive the outputs in the same cycle. valid_A=in_valid_A; valid_B=in_valid_A&&in_valid_B.
  - The pop count applies to the bypassed entries first; only the un-consumed remainder is written.
  - Example: count=0, push 2, deq_count=1 leaves B stored at head, count=1.
- IFQ_BYPASS_EN undefined: no bypass. The minimum fetch-to-decoder latency is 1 cycle.

## Test plan
- Reset, then push A=32'h00500093/pc 0x0 and B=32'h00a00113/pc 0x4, deq_count=0 -> next cycle count=2, valid_A=valid_B=1, instA=32'h00500093, pcB=0x4.
- With DEPTH=8, fill to 8 in 2-wide pushes -> in_ready=0 at count=7 and count=8. A further push sets overflow_err=1 and count stays unchanged.
- Wrap: push and pop 2 per cycle for 10 cycles with sequential PCs -> pcA increments by 8 each cycle, count stays 2, with no reordering across the index 7->0 boundary.
- count=1 with deq_count=2 -> count=0, valid_A=0, instA=32'h00000013, pcA=0.
- count=5 with flush=1, push 2 and deq_count=2 in the same cycle -> next cycle count=0, valid_A=0, in_ready=1.
- IFQ_BYPASS_EN build: queue empty, push A/B with deq_count=1 -> same cycle instA=in_instA. Next cycle instA=old in_instB and count=1.
